// File: rtl/thread_seq_checker.sv
// Receiver end of the engine thread-number sequence: registers each accepted number as
// core/ctx/seq fields, checks it against the expected successor and counts completed rounds.
module thread_seq_checker #(
    parameter int N_CORES         = 3,
    parameter int N_CORES_MSB     = (N_CORES > 1) ? $clog2(N_CORES) - 1 : 0,
    parameter int N_THREADS       = 4 * N_CORES,
    parameter int N_THREADS_MSB   = $clog2(N_THREADS) - 1,
    parameter int ROUND_CNT_WIDTH = 16
) (
    input  logic                       CLK,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [N_THREADS_MSB:0]     in_thread_num,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_CORES_MSB:0]       out_core_num,
    output logic                       out_ctx_num,
    output logic                       out_seq_num,
    output logic                       out_bad,
    input  logic                       clr_err,
    output logic                       err_seq,
    output logic                       err_range,
    output logic [N_THREADS_MSB:0]     err_thread_num,
    output logic [ROUND_CNT_WIDTH-1:0] round_cnt
);

    localparam int FW = N_THREADS_MSB;
    localparam logic [FW-1:0] F_LAST = FW'(2 * N_CORES - 1);

    logic                       r_out_valid;
    logic [N_CORES_MSB:0]       r_core_num;
    logic                       r_ctx_num;
    logic                       r_seq_num;
    logic                       r_bad;
    logic [N_THREADS_MSB:0]     r_expected;
    logic                       r_err_seq;
    logic                       r_err_range;
    logic [N_THREADS_MSB:0]     r_err_thread_num;
    logic [ROUND_CNT_WIDTH-1:0] r_round_cnt;

    logic                       w_in_ready;
    logic                       w_accept;
    logic [FW-1:0]              w_f;
    logic                       w_seq;
    logic                       w_range_bad;
    logic                       w_seq_bad;
    logic                       w_bad;
    logic [N_THREADS_MSB:0]     w_next_expected;
    logic                       w_round_done;
    logic                       w_load_err;

    always_comb begin
        w_in_ready  = !r_out_valid || out_ready;
        w_accept    = in_valid && w_in_ready;
        w_f         = in_thread_num[N_THREADS_MSB:1];
        w_seq       = in_thread_num[0];
        w_range_bad = (w_f > F_LAST);
        w_seq_bad   = !w_range_bad && (in_thread_num != r_expected);
        w_bad       = w_range_bad || w_seq_bad;

        // An out-of-range field resyncs exactly like the last slot of a round: back to 0, seq flips.
        if (w_f >= F_LAST) begin
            w_next_expected = {{FW{1'b0}}, ~w_seq};
        end else begin
            w_next_expected = {w_f + FW'(1), w_seq};
        end

        w_round_done = w_accept && !w_bad && (w_f == F_LAST) && w_seq;
        w_load_err   = w_accept && w_bad && (clr_err || (!r_err_seq && !r_err_range));
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_core_num  <= '0;
            r_ctx_num   <= 1'b0;
            r_seq_num   <= 1'b0;
            r_bad       <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_core_num  <= (N_CORES_MSB + 1)'(in_thread_num[N_THREADS_MSB:2]);
            r_ctx_num   <= in_thread_num[1];
            r_seq_num   <= w_seq;
            r_bad       <= w_bad;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_expected <= '0;
        end else if (w_accept) begin
            r_expected <= w_next_expected;
        end
    end

    // A clear in the same cycle as a new error leaves that new error recorded.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_err_seq        <= 1'b0;
            r_err_range      <= 1'b0;
            r_err_thread_num <= '0;
        end else begin
            r_err_seq   <= (r_err_seq && !clr_err) || (w_accept && w_seq_bad);
            r_err_range <= (r_err_range && !clr_err) || (w_accept && w_range_bad);
            if (w_load_err) begin
                r_err_thread_num <= in_thread_num;
            end else if (clr_err) begin
                r_err_thread_num <= '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_round_cnt <= '0;
        end else if (w_round_done && (r_round_cnt != '1)) begin
            r_round_cnt <= r_round_cnt + ROUND_CNT_WIDTH'(1);
        end
    end

    assign in_ready       = w_in_ready;
    assign out_valid      = r_out_valid;
    assign out_core_num   = r_core_num;
    assign out_ctx_num    = r_ctx_num;
    assign out_seq_num    = r_seq_num;
    assign out_bad        = r_bad;
    assign err_seq        = r_err_seq;
    assign err_range      = r_err_range;
    assign err_thread_num = r_err_thread_num;
    assign round_cnt      = r_round_cnt;

endmodule

// File: tb/tb_thread_seq_checker.sv
// Bench for thread_seq_checker: directed thread-number streams with a scoreboard on the
// output handshake, plus direct checks of the sticky error flags and the round counter.
module tb_thread_seq_checker;

    logic       CLK;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_thread_num;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_core_num;
    logic       out_ctx_num;
    logic       out_seq_num;
    logic       out_bad;
    logic       clr_err;
    logic       err_seq;
    logic       err_range;
    logic [3:0] err_thread_num;
    logic [3:0] round_cnt;

    typedef struct {
        logic [3:0] num;
        logic       bad;
    } exp_t;

    exp_t scoreQ[$];
    int   checks      = 0;
    int   errors      = 0;
    int   pushCount   = 0;
    int   popCount    = 0;
    int   stallCycles = 0;
    int   order[12]   = '{0, 2, 4, 6, 8, 10, 1, 3, 5, 7, 9, 11};

    // Round counter narrowed so saturation is reachable in a short run.
    thread_seq_checker #(.ROUND_CNT_WIDTH(4)) dut (
        .CLK            (CLK),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_thread_num  (in_thread_num),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_core_num   (out_core_num),
        .out_ctx_num    (out_ctx_num),
        .out_seq_num    (out_seq_num),
        .out_bad        (out_bad),
        .clr_err        (clr_err),
        .err_seq        (err_seq),
        .err_range      (err_range),
        .err_thread_num (err_thread_num),
        .round_cnt      (round_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Offers one number; the expected entry is queued on the cycle the DUT will accept it.
    task automatic applyStimulus(input logic [3:0] num, input logic expBad);
        int   waited;
        bit   done;
        exp_t e;
        waited        = 0;
        done          = 1'b0;
        in_valid      = 1'b1;
        in_thread_num = num;
        while (!done && waited < 50) begin
            @(negedge CLK);
            if (in_ready) begin
                e.num = num;
                e.bad = expBad;
                scoreQ.push_back(e);
                pushCount++;
                done = 1'b1;
            end else begin
                waited++;
            end
            @(posedge CLK);
            #1;
        end
        in_valid     = 1'b0;
        stallCycles += waited;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: number %0d not accepted in %0d cycles", num, waited);
        end
    endtask

    // Monitor: an entry presented with out_ready high leaves at the next edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (rst_n && out_valid && out_ready) begin
                popCount++;
                if (scoreQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_unexpected: got entry %0d, expected none",
                             {out_core_num, out_ctx_num, out_seq_num});
                end else begin
                    e = scoreQ.pop_front();
                    checkOutput("sb_fields", {out_core_num, out_ctx_num, out_seq_num}, e.num);
                    checkOutput("sb_bad", out_bad, e.bad);
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_thread_num = '0;
        out_ready     = 1'b1;
        clr_err       = 1'b0;

        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_fields", {out_core_num, out_ctx_num, out_seq_num}, 0);
        checkOutput("rst_out_bad", out_bad, 0);
        checkOutput("rst_err_seq", err_seq, 0);
        checkOutput("rst_err_range", err_range, 0);
        checkOutput("rst_err_num", err_thread_num, 0);
        checkOutput("rst_round_cnt", round_cnt, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge CLK);
        #1;

        // One clean round plus the wrap back to 0, back to back.
        stallCycles = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(4'(order[i]), 1'b0);
            if (i == 10) checkOutput("round_before_11", round_cnt, 0);
        end
        checkOutput("round_after_11", round_cnt, 1);
        applyStimulus(4'd0, 1'b0);
        checkOutput("stream_no_stall", stallCycles, 0);
        checkOutput("stream_err_seq", err_seq, 0);
        checkOutput("stream_err_range", err_range, 0);

        // Skipped number, then resync to its successor.
        applyStimulus(4'd2, 1'b0);
        applyStimulus(4'd6, 1'b1);
        checkOutput("skip_err_seq", err_seq, 1);
        checkOutput("skip_err_range", err_range, 0);
        checkOutput("skip_err_num", err_thread_num, 6);
        applyStimulus(4'd8, 1'b0);
        checkOutput("resync_err_num_held", err_thread_num, 6);

        clr_err = 1'b1;
        @(posedge CLK);
        #1;
        clr_err = 1'b0;
        checkOutput("clr_err_seq", err_seq, 0);
        checkOutput("clr_err_num", err_thread_num, 0);
        checkOutput("clr_round_kept", round_cnt, 1);
        applyStimulus(4'd10, 1'b0);

        // Out-of-range field values.
        applyStimulus(4'd12, 1'b1);
        checkOutput("range_err_range", err_range, 1);
        checkOutput("range_err_seq", err_seq, 0);
        checkOutput("range_err_num", err_thread_num, 12);
        applyStimulus(4'd1, 1'b0);
        applyStimulus(4'd14, 1'b1);
        checkOutput("range2_err_num_first", err_thread_num, 12);
        applyStimulus(4'd1, 1'b0);

        // Clear and a new sequence error in the same cycle.
        clr_err = 1'b1;
        applyStimulus(4'd7, 1'b1);
        clr_err = 1'b0;
        checkOutput("clr_same_err_seq", err_seq, 1);
        checkOutput("clr_same_err_range", err_range, 0);
        checkOutput("clr_same_err_num", err_thread_num, 7);

        // Backpressure: one entry held while the next is offered for 5 cycles.
        repeat (2) @(posedge CLK);
        #1;
        out_ready = 1'b0;
        applyStimulus(4'd9, 1'b0);
        fork
            applyStimulus(4'd11, 1'b0);
            begin
                repeat (5) begin
                    @(negedge CLK);
                    checkOutput("hold_out_valid", out_valid, 1);
                    checkOutput("hold_in_ready", in_ready, 0);
                    checkOutput("hold_data", {out_core_num, out_ctx_num, out_seq_num}, 9);
                end
                @(posedge CLK);
                #1;
                out_ready = 1'b1;
            end
        join
        checkOutput("hold_round_cnt", round_cnt, 2);

        // Asynchronous reset between edges with state outstanding.
        applyStimulus(4'd0, 1'b0);
        applyStimulus(4'd2, 1'b0);
        @(negedge CLK);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_out_valid", out_valid, 0);
        checkOutput("async_out_fields", {out_core_num, out_ctx_num, out_seq_num}, 0);
        checkOutput("async_err_seq", err_seq, 0);
        checkOutput("async_err_num", err_thread_num, 0);
        checkOutput("async_round_cnt", round_cnt, 0);
        checkOutput("async_queue_empty", scoreQ.size(), 0);
        #1;
        rst_n = 1'b1;
        @(posedge CLK);
        #1;
        applyStimulus(4'd0, 1'b0);
        applyStimulus(4'd2, 1'b0);

        // Run the counter up to all-ones and one round beyond.
        for (int i = 2; i < 180; i++) applyStimulus(4'(order[i % 12]), 1'b0);
        checkOutput("sat_reach", round_cnt, 15);
        for (int i = 180; i < 192; i++) applyStimulus(4'(order[i % 12]), 1'b0);
        checkOutput("sat_hold", round_cnt, 15);
        checkOutput("sat_err_seq", err_seq, 0);
        checkOutput("sat_err_range", err_range, 0);

        repeat (3) @(posedge CLK);
        #1;
        checkOutput("final_queue_empty", scoreQ.size(), 0);
        checkOutput("final_push_pop", popCount, pushCount);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
